// File: rtl/tick_gen_if.sv
// tick_gen_if: control/status bundle for tick_gen; master drives enables, starts and config writes.
interface tick_gen_if #(
    parameter int WIDTH = 27,
    parameter int NCH   = 4,
    parameter int CHW   = 2
);
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   start;
    logic             wr_en;
    logic [CHW-1:0]   wr_ch;
    logic [WIDTH-1:0] wr_div;
    logic             wr_oneshot;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   sq;
    logic [NCH-1:0]   busy;
    modport master (output en, start, wr_en, wr_ch, wr_div, wr_oneshot, input tick, sq, busy);
    modport slave  (input en, start, wr_en, wr_ch, wr_div, wr_oneshot, output tick, sq, busy);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: NCH independent programmable tick/square-wave channels with periodic and one-shot modes.
module tick_gen #(
    parameter int WIDTH       = 27,
    parameter int NCH         = 4,
    parameter int CHW         = 2,
    parameter int DEFAULT_DIV = 100_000_000
) (
    input logic       clk,
    input logic       reset,
    tick_gen_if.slave bus
);
    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [WIDTH-1:0] cnt, div, last;
        logic             mode, tick_r, sq_r, busy_r;
        logic             wr_hit, run, fire;
        // divisors 0 and 1 both collapse to a terminal count of 0
        assign last   = (div > WIDTH'(1)) ? div - WIDTH'(1) : '0;
        assign wr_hit = bus.wr_en && bus.wr_ch == CHW'(g);
        assign run    = bus.en[g] && (!mode || busy_r);
        assign fire   = run && cnt == last;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                div    <= DEF;
                mode   <= 1'b0;
                tick_r <= 1'b0;
                sq_r   <= 1'b0;
                busy_r <= 1'b0;
            end else if (wr_hit) begin
                cnt    <= '0;
                div    <= bus.wr_div;
                mode   <= bus.wr_oneshot;
                tick_r <= 1'b0;
                sq_r   <= 1'b0;
                busy_r <= 1'b0;
            end else begin
                tick_r <= fire;
                sq_r   <= sq_r ^ fire;
                cnt    <= (bus.start[g] || fire) ? '0 : run ? cnt + WIDTH'(1) : cnt;
                busy_r <= mode && (bus.start[g] || (busy_r && !fire));
            end
        end
        assign bus.tick[g] = tick_r;
        assign bus.sq[g]   = sq_r;
        assign bus.busy[g] = busy_r;
    end
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: vector-table and scoreboard bench for tick_gen (3 channels, 8-bit, default divisor 5).
module tb_tick_gen;
    typedef struct {
        string      nm;
        logic       rst;
        logic [2:0] en;
        logic [2:0] st;
        logic       wr;
        logic [1:0] ch;
        logic [7:0] dv;
        logic       os;
        logic [2:0] t;
        logic [2:0] s;
        logic [2:0] b;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vq[$];
    vec_t exp_q[$];

    tick_gen_if #(.WIDTH(8), .NCH(3), .CHW(2)) bus ();
    tick_gen #(.WIDTH(8), .NCH(3), .CHW(2), .DEFAULT_DIV(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic void add(string nm, logic r, logic [2:0] en, logic [2:0] st, logic wr, logic [1:0] ch,
                                logic [7:0] dv, logic os, logic [2:0] t, logic [2:0] s, logic [2:0] b);
        vec_t v;
        v.nm = nm; v.rst = r; v.en = en; v.st = st; v.wr = wr; v.ch = ch;
        v.dv = dv; v.os = os; v.t = t; v.s = s; v.b = b;
        vq.push_back(v);
    endfunction

    function automatic void cyc(string nm, logic [2:0] en, logic [2:0] st, logic [2:0] t, logic [2:0] s, logic [2:0] b);
        add(nm, 1'b0, en, st, 1'b0, 2'd0, 8'd0, 1'b0, t, s, b);
    endfunction

    function automatic void wrv(string nm, logic [1:0] ch, logic [7:0] dv, logic os, logic [2:0] en, logic [2:0] st,
                                logic [2:0] t, logic [2:0] s, logic [2:0] b);
        add(nm, 1'b0, en, st, 1'b1, ch, dv, os, t, s, b);
    endfunction

    task automatic check(string nm, int idx, logic [8:0] got, logic [8:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d]: tick/sq/busy got %b_%b_%b expected %b_%b_%b", nm, idx,
                     got[8:6], got[5:3], got[2:0], want[8:6], want[5:3], want[2:0]);
        end
    endtask

    task automatic drive(vec_t v);
        @(negedge clk);
        reset = v.rst; bus.en = v.en; bus.start = v.st; bus.wr_en = v.wr;
        bus.wr_ch = v.ch; bus.wr_div = v.dv; bus.wr_oneshot = v.os;
        exp_q.push_back(v);
    endtask

    task automatic cmp_int(string nm, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    initial begin
        vec_t e;
        int   nt0, nt1, nt2, both, all3;
        bus.en = '0; bus.start = '0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0; bus.wr_oneshot = 1'b0;
        // reset, then default divisor 5 on ch0
        add("rst", 1, 3'b000, 3'b000, 0, 2'd0, 8'd0, 0, 3'b000, 3'b000, 3'b000);
        add("rst_ovr", 1, 3'b111, 3'b111, 1, 2'd0, 8'd2, 1, 3'b000, 3'b000, 3'b000);
        for (int k = 1; k <= 15; k++)
            cyc("per5", 3'b001, 3'b000, (k % 5 == 0) ? 3'b001 : 3'b000, ((k / 5) % 2 == 1) ? 3'b001 : 3'b000, 3'b000);
        // reset mid-count at cnt=3
        for (int k = 0; k < 3; k++) cyc("pre_rst", 3'b001, 3'b000, 3'b000, 3'b001, 3'b000);
        add("mid_rst", 1, 3'b001, 3'b000, 0, 2'd0, 8'd0, 0, 3'b000, 3'b000, 3'b000);
        for (int k = 1; k <= 5; k++)
            cyc("post_rst", 3'b001, 3'b000, (k == 5) ? 3'b001 : 3'b000, (k == 5) ? 3'b001 : 3'b000, 3'b000);
        for (int k = 0; k < 2; k++) cyc("en_hold", 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
        // gating and resync on ch1, div 4
        add("rst", 1, 3'b000, 3'b000, 0, 2'd0, 8'd0, 0, 3'b000, 3'b000, 3'b000);
        wrv("wr_ch1", 2'd1, 8'd4, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 2; k++) cyc("gate_on", 3'b010, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) cyc("gate_off", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        cyc("gate_on2", 3'b010, 3'b000, 3'b000, 3'b000, 3'b000);
        cyc("gate_tick", 3'b010, 3'b000, 3'b010, 3'b010, 3'b000);
        cyc("cnt1", 3'b010, 3'b000, 3'b000, 3'b010, 3'b000);
        wrv("wr_other", 2'd2, 8'd7, 0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000);
        cyc("resync", 3'b010, 3'b010, 3'b000, 3'b010, 3'b000);
        for (int k = 0; k < 3; k++) cyc("after_resync", 3'b010, 3'b000, 3'b000, 3'b010, 3'b000);
        cyc("resync_tick", 3'b010, 3'b000, 3'b010, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) cyc("to_term", 3'b010, 3'b000, 3'b000, 3'b000, 3'b000);
        cyc("start_term", 3'b010, 3'b010, 3'b010, 3'b010, 3'b000);
        for (int k = 0; k < 3; k++) cyc("after_st", 3'b010, 3'b000, 3'b000, 3'b010, 3'b000);
        cyc("after_st_tick", 3'b010, 3'b000, 3'b010, 3'b000, 3'b000);
        // one-shot on ch2, div 3
        add("rst", 1, 3'b000, 3'b000, 0, 2'd0, 8'd0, 0, 3'b000, 3'b000, 3'b000);
        wrv("wr_os", 2'd2, 8'd3, 1, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000);
        cyc("os_idle", 3'b100, 3'b000, 3'b000, 3'b000, 3'b000);
        cyc("os_start", 3'b100, 3'b100, 3'b000, 3'b000, 3'b100);
        for (int k = 0; k < 2; k++) cyc("os_busy", 3'b100, 3'b000, 3'b000, 3'b000, 3'b100);
        cyc("os_tick", 3'b100, 3'b000, 3'b100, 3'b100, 3'b000);
        for (int k = 0; k < 3; k++) cyc("os_quiet", 3'b100, 3'b000, 3'b000, 3'b100, 3'b000);
        cyc("os_start2", 3'b100, 3'b100, 3'b000, 3'b100, 3'b100);
        cyc("os_cnt1", 3'b100, 3'b000, 3'b000, 3'b100, 3'b100);
        cyc("retrig", 3'b100, 3'b100, 3'b000, 3'b100, 3'b100);
        for (int k = 0; k < 2; k++) cyc("retrig_busy", 3'b100, 3'b000, 3'b000, 3'b100, 3'b100);
        cyc("retrig_tick", 3'b100, 3'b000, 3'b100, 3'b000, 3'b000);
        cyc("os_start3", 3'b100, 3'b100, 3'b000, 3'b000, 3'b100);
        for (int k = 0; k < 2; k++) cyc("os_en_hold", 3'b000, 3'b000, 3'b000, 3'b000, 3'b100);
        for (int k = 0; k < 2; k++) cyc("os_resume", 3'b100, 3'b000, 3'b000, 3'b000, 3'b100);
        cyc("os_start_term", 3'b100, 3'b100, 3'b100, 3'b100, 3'b100);
        for (int k = 0; k < 2; k++) cyc("os_after", 3'b100, 3'b000, 3'b000, 3'b100, 3'b100);
        cyc("os_final", 3'b100, 3'b000, 3'b100, 3'b000, 3'b000);
        // boundary divisors, out-of-range channel, write versus start
        add("rst", 1, 3'b000, 3'b000, 0, 2'd0, 8'd0, 0, 3'b000, 3'b000, 3'b000);
        wrv("wr_div0", 2'd0, 8'd0, 0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
        cyc("div0", 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
        cyc("div0", 3'b001, 3'b000, 3'b001, 3'b000, 3'b000);
        cyc("div0", 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
        wrv("wr_clr", 2'd0, 8'd1, 0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
        cyc("div1", 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
        cyc("div1", 3'b001, 3'b000, 3'b001, 3'b000, 3'b000);
        cyc("div1_off", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        wrv("wr_oob", 2'd3, 8'd2, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        cyc("oob_kept", 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
        wrv("wr_vs_start", 2'd0, 8'd3, 1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
        cyc("wr_won", 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);

        foreach (vq[i]) begin
            drive(vq[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check(e.nm, i, {bus.tick, bus.sq, bus.busy}, {e.t, e.s, e.b});
        end

        // long multi-channel run: divisors 3, 3, 6 with all channels enabled
        @(negedge clk);
        reset = 1'b1; bus.en = '0; bus.start = '0; bus.wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0; bus.wr_en = 1'b1; bus.wr_oneshot = 1'b0; bus.wr_ch = 2'd0; bus.wr_div = 8'd3;
        @(negedge clk);
        bus.wr_ch = 2'd1;
        @(negedge clk);
        bus.wr_ch = 2'd2; bus.wr_div = 8'd6;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.en = 3'b111;
        nt0 = 0; nt1 = 0; nt2 = 0; both = 0; all3 = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            nt0 += int'(bus.tick[0]);
            nt1 += int'(bus.tick[1]);
            nt2 += int'(bus.tick[2]);
            both += int'(bus.tick[0] && bus.tick[1]);
            all3 += int'(&bus.tick);
        end
        cmp_int("long_ticks_ch0", nt0, 20);
        cmp_int("long_ticks_ch1", nt1, 20);
        cmp_int("long_ticks_ch2", nt2, 10);
        cmp_int("long_coincide_01", both, 20);
        cmp_int("long_coincide_all", all3, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
